bit_serial_adder: RTL and testbench

//  Adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first.
//  A single 1-bit full-adder cell and a registered carry are reused across all bit positions.
//  The block is the additive counterpart of the bit-level subtractor datapath.
//  It serves area-constrained datapaths that trade latency for gates, using a start/busy/done handshake.

---
 rtl/bit_serial_adder.sv | 134 +++++++++++++
 tb/tb_bit_serial_adder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_adder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : bit_serial_adder
// Brief  : WIDTH-bit adder using one full-adder cell and a registered carry,
//          one bit per clock, LSB first, with start/busy/done handshake.
// Rev    : 1.0  initial release
// ============================================================================
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               fa_sum;
    logic               fa_carry;
    logic [WIDTH:0]     acc_ext;
    logic [WIDTH-1:0]   acc_next;

    // The single full-adder cell shared by every bit position.
    assign fa_sum   = sa_q[0] ^ sb_q[0] ^ carry_q;
    assign fa_carry = (sa_q[0] & sb_q[0]) | (carry_q & (sa_q[0] ^ sb_q[0]));
    assign acc_ext  = {fa_sum, acc_q};
    assign acc_next = acc_ext[WIDTH:1];

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    carry_d = cin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                carry_d = fa_carry;
                acc_d   = acc_next;
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                // Results are published only once all bits are in, so sum
                // never shows a partial value.
                if (cnt_q == LAST_CNT) begin
                    sum_d   = acc_next;
                    cout_d  = fa_carry;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_adder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_bit_serial_adder
// Brief  : Self-checking bench for bit_serial_adder (WIDTH=8 and WIDTH=1).
// Rev    : 1.0  initial release
// ============================================================================
module tb_bit_serial_adder;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;

    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt8 = 0;
    int done_cnt1 = 0;

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    bit_serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    always @(negedge clk) begin
        if (done8 === 1'b1) done_cnt8++;
        if (done1 === 1'b1) done_cnt1++;
    end

    // Drives one 8-bit operation; operands and start are scrambled while busy.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       output logic [8:0] res, output int lat, output int busy_n,
                       output bit glitch, output logic done_after);
        logic [7:0] sum_prev;
        logic       cout_prev;
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        sum_prev = sum8; cout_prev = cout8;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0; busy_n = 0; glitch = 1'b0;
        while (done8 !== 1'b1 && lat < 40) begin
            if (busy8 === 1'b1) busy_n++;
            if (sum8 !== sum_prev || cout8 !== cout_prev) glitch = 1'b1;
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            start8 = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        start8 = 1'b0;
        res = {cout8, sum8};
        @(negedge clk);
        done_after = done8;
    endtask

    task automatic op1(input logic a, input logic b, input logic c,
                       output logic [1:0] res, output int lat);
        @(negedge clk);
        a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 0;
        while (done1 !== 1'b1 && lat < 20) begin
            a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        res = {cout1, sum1};
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy8 !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy8); else n_pass++;
        n_checks++; if (done8 !== 1'b0) $display("FAIL reset_done got=%b exp=0", done8); else n_pass++;
        n_checks++; if (sum8 !== 8'h00) $display("FAIL reset_sum got=%h exp=00", sum8); else n_pass++;
        n_checks++; if (cout8 !== 1'b0) $display("FAIL reset_cout got=%b exp=0", cout8); else n_pass++;
        n_checks++; if ({busy1, done1, sum1, cout1} !== 4'b0)
            $display("FAIL reset_w1 got=%b exp=0000", {busy1, done1, sum1, cout1}); else n_pass++;
        rst = 1'b0;
        a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if ({busy8, done8, sum8, cout8} !== 11'b0)
            $display("FAIL idle_no_start got=%b exp=0", {busy8, done8, sum8, cout8}); else n_pass++;
    endtask

    task automatic test_directed();
        logic [7:0] ta[3] = '{8'h5A, 8'hFF, 8'hFF};
        logic [7:0] tb[3] = '{8'h3C, 8'h01, 8'hFF};
        logic       tc[3] = '{1'b0, 1'b0, 1'b1};
        logic [8:0] te[3] = '{9'h096, 9'h100, 9'h1FF};
        logic [8:0] res;
        int lat, busy_n;
        bit glitch;
        logic done_after;
        for (int i = 0; i < 3; i++) begin
            op8(ta[i], tb[i], tc[i], res, lat, busy_n, glitch, done_after);
            n_checks++; if (res !== te[i]) $display("FAIL dir_result[%0d] got=%h exp=%h", i, res, te[i]); else n_pass++;
            n_checks++; if (lat !== 8) $display("FAIL dir_latency[%0d] got=%0d exp=8", i, lat); else n_pass++;
            n_checks++; if (busy_n !== 8) $display("FAIL dir_busy_cycles[%0d] got=%0d exp=8", i, busy_n); else n_pass++;
            n_checks++; if (glitch !== 1'b0) $display("FAIL dir_partial_visible[%0d] got=%b exp=0", i, glitch); else n_pass++;
            n_checks++; if (done_after !== 1'b0) $display("FAIL dir_done_width[%0d] got=%b exp=0", i, done_after); else n_pass++;
        end
    endtask

    // start held high: acceptances fall every WIDTH+2 cycles.
    task automatic test_back_to_back();
        logic [8:0] q[$];
        logic [8:0] exp;
        logic       exp_done;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            exp_done = (i % 10 == 9);
            n_checks++; if (done8 !== exp_done)
                $display("FAIL b2b_done_cycle[%0d] got=%b exp=%b", i, done8, exp_done); else n_pass++;
            if (exp_done) begin
                exp = (q.size() > 0) ? q.pop_front() : 9'h000;
                n_checks++; if ({cout8, sum8} !== exp)
                    $display("FAIL b2b_result[%0d] got=%h exp=%h", i, {cout8, sum8}, exp); else n_pass++;
            end
            if (i < 49) begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
                start8 = 1'b1;
                if (i % 10 == 0) q.push_back(9'(a8) + 9'(b8) + 9'(cin8));
            end else begin
                start8 = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        bit saw_done;
        logic [8:0] res;
        int lat, busy_n;
        bit glitch;
        logic done_after;
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++; if ({busy8, done8, sum8, cout8} !== 11'b0)
            $display("FAIL abort_async_clear got=%b exp=0", {busy8, done8, sum8, cout8}); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done8 === 1'b1) saw_done = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0) $display("FAIL abort_no_done got=%b exp=0", saw_done); else n_pass++;
        n_checks++; if ({cout8, sum8} !== 9'h000) $display("FAIL abort_outputs got=%h exp=000", {cout8, sum8}); else n_pass++;
        op8(8'h12, 8'h34, 1'b0, res, lat, busy_n, glitch, done_after);
        n_checks++; if (res !== 9'h046) $display("FAIL abort_retry got=%h exp=046", res); else n_pass++;
    endtask

    task automatic test_random_sweep();
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] res, exp;
        logic [1:0] res1, exp1;
        int lat, busy_n, d0, bad8, bad1;
        bit glitch;
        logic done_after;
        d0 = done_cnt8;
        bad8 = 0;
        for (int i = 0; i < 600; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            exp = 9'(ra) + 9'(rb) + 9'(rc);
            op8(ra, rb, rc, res, lat, busy_n, glitch, done_after);
            n_checks++;
            if (res !== exp || lat !== 8 || glitch) begin
                $display("FAIL rand8[%0d] got=%h lat=%0d exp=%h lat=8", i, res, lat, exp);
                bad8++;
            end else n_pass++;
        end
        n_checks++; if (done_cnt8 - d0 !== 600)
            $display("FAIL rand8_done_count got=%0d exp=600", done_cnt8 - d0); else n_pass++;

        d0 = done_cnt1;
        bad1 = 0;
        for (int i = 0; i < 600; i++) begin
            rc = 1'($urandom);
            ra[0] = 1'($urandom); rb[0] = 1'($urandom);
            exp1 = 2'(ra[0]) + 2'(rb[0]) + 2'(rc);
            op1(ra[0], rb[0], rc, res1, lat);
            n_checks++;
            if (res1 !== exp1 || lat !== 1) begin
                $display("FAIL rand1[%0d] got=%b lat=%0d exp=%b lat=1", i, res1, lat, exp1);
                bad1++;
            end else n_pass++;
        end
        n_checks++; if (done_cnt1 - d0 !== 600)
            $display("FAIL rand1_done_count got=%0d exp=600", done_cnt1 - d0); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_abort();
        test_random_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
